// File: rtl/mc_scheduler_if.sv
// mc_scheduler_if: host load/result handshake plus the broadcast core bus of the scheduler
interface mc_scheduler_if #(
  parameter int NCORES = 4,
  parameter int LOG_NCORES = 2,
  parameter int LOGT = 9,
  parameter int PATH_W = 10,
  parameter int ACC_W = 27
);
  logic [17:0] load_data;
  logic load_valid;
  logic load_ready;
  logic [PATH_W-1:0] sigma_addr;
  logic [LOGT-1:0] mu_addr;
  logic [17:0] write_data;
  logic sigma_we;
  logic mu_we;
  logic pp_switch;
  logic start;
  logic [NCORES-1:0] core_done;
  logic [NCORES*ACC_W-1:0] core_acc;
  logic [ACC_W+LOG_NCORES-1:0] result;
  logic result_valid;
  logic result_ready;
  logic busy;
  logic timeout;
  modport master (
    output load_data, load_valid, core_done, core_acc, result_ready,
    input load_ready, sigma_addr, mu_addr, write_data, sigma_we, mu_we, pp_switch, start,
    result, result_valid, busy, timeout
  );
  modport slave (
    input load_data, load_valid, core_done, core_acc, result_ready,
    output load_ready, sigma_addr, mu_addr, write_data, sigma_we, mu_we, pp_switch, start,
    result, result_valid, busy, timeout
  );
endinterface

// File: rtl/mc_scheduler.sv
// mc_scheduler: loads ping-pong tables into a bank of MC cores, runs them and sums their results
module mc_scheduler #(
  parameter int NCORES = 4,
  parameter int LOG_NCORES = 2,
  parameter int LOGT = 9,
  parameter int PATH_W = 10,
  parameter int ACC_W = 27,
  parameter int TIMEOUT = 4096
) (
  input logic clk,
  input logic rst,
  mc_scheduler_if.slave bus
);
  localparam int CNT_W = PATH_W + 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int RES_W = ACC_W + LOG_NCORES;
  typedef enum logic [1:0] {IDLE, RUN, SUM, OUT} state_t;
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic buf_full;
  logic xfer;
  logic last;
  logic go;
  logic [NCORES-1:0] mask;
  logic [NCORES-1:0] mask_n;
  logic [WD_W-1:0] wdog;
  logic [LOG_NCORES-1:0] idx;
  assign bus.load_ready = ~buf_full & ~rst;
  assign xfer = bus.load_valid & bus.load_ready;
  assign last = cnt == CNT_W'((1 << PATH_W) + (1 << LOGT) - 1);
  // start only once the final mu write has landed, so the switch never flips under it
  assign go = (state == IDLE) & buf_full & ~bus.mu_we;
  assign mask_n = mask | bus.core_done;
  assign bus.busy = state != IDLE;
  // load engine: sigma words first, then mu words, written one cycle after transfer
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      buf_full <= 1'b0;
      bus.sigma_we <= 1'b0;
      bus.mu_we <= 1'b0;
      bus.sigma_addr <= '0;
      bus.mu_addr <= '0;
      bus.write_data <= '0;
    end else begin
      bus.sigma_we <= xfer & ~cnt[PATH_W];
      bus.mu_we <= xfer & cnt[PATH_W];
      if (xfer) begin
        bus.sigma_addr <= cnt[PATH_W-1:0];
        bus.mu_addr <= cnt[LOGT-1:0];
        bus.write_data <= bus.load_data;
        cnt <= last ? '0 : cnt + CNT_W'(1);
      end
      buf_full <= (buf_full & ~go) | (xfer & last);
    end
  // run FSM: start the bank, collect done flags with a watchdog, then sum and hand off
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      bus.pp_switch <= 1'b0;
      bus.start <= 1'b0;
      bus.result <= '0;
      bus.result_valid <= 1'b0;
      bus.timeout <= 1'b0;
      mask <= '0;
      wdog <= '0;
      idx <= '0;
    end else begin
      bus.start <= go;
      case (state)
        IDLE: if (go) begin
          bus.pp_switch <= ~bus.pp_switch;
          mask <= '0;
          wdog <= '0;
          state <= RUN;
        end
        RUN: begin
          mask <= mask_n;
          wdog <= wdog + WD_W'(1);
          if (&mask_n) begin
            state <= SUM;
            idx <= '0;
            bus.result <= '0;
          end else if (wdog == WD_W'(TIMEOUT - 1)) begin
            bus.timeout <= 1'b1;
            state <= IDLE;
          end
        end
        SUM: begin
          bus.result <= bus.result + RES_W'(bus.core_acc[idx*ACC_W +: ACC_W]);
          idx <= idx + LOG_NCORES'(1);
          if (idx == LOG_NCORES'(NCORES - 1)) begin
            state <= OUT;
            bus.result_valid <= 1'b1;
          end
        end
        OUT: if (bus.result_ready) begin
          bus.result_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mc_scheduler.sv
// tb_mc_scheduler: scoreboard bench for table loading, run sequencing, summing and timeout
module tb_mc_scheduler;
  localparam int NCORES = 4;
  localparam int TIMEOUT = 4096;
  localparam int SN = 1024;
  localparam int MN = 512;
  typedef struct {
    logic [1:0] kind;
    logic [9:0] addr;
    logic [17:0] data;
  } wr_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int wpos = 0;
  int stalls = 0;
  int nstart = 0;
  logic sw_exp = 1'b0;
  logic psw = 1'b0;
  logic prst = 1'b1;
  logic pst = 1'b0;
  logic pmu = 1'b0;
  wr_t wq[$];
  logic [63:0] rq[$];
  mc_scheduler_if bus ();
  mc_scheduler dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load_words(input int base, input int n);
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      bus.load_data = 18'(base + i);
      bus.load_valid = 1'b1;
      @(negedge clk);
      for (int w = 0; w < 50 && !bus.load_ready; w++) begin
        stalls++;
        @(negedge clk);
      end
      if (!bus.load_ready) begin
        chk("load_stall", bus.load_ready, 1);
        bus.load_valid = 1'b0;
        return;
      end
      wq.push_back('{kind: (wpos < SN) ? 2'b10 : 2'b01,
                     addr: 10'((wpos < SN) ? wpos : wpos - SN), data: 18'(base + i)});
      wpos = (wpos + 1) % (SN + MN);
      @(posedge clk);
      #1;
    end
    bus.load_valid = 1'b0;
    chk("load_stalls", stalls, 0);
  endtask
  task automatic wait_start;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.start;
    end
    chk("start_seen", seen, 1);
  endtask
  task automatic pulse_done(input logic [NCORES-1:0] m);
    bus.core_done = m;
    @(posedge clk);
    #1;
    bus.core_done = '0;
  endtask
  // monitors: write scoreboard, result scoreboard, start/switch behaviour
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (bus.sigma_we || bus.mu_we) begin
      if (wq.size() == 0) chk("wr_spurious", {bus.sigma_we, bus.mu_we}, 0);
      else begin
        e = wq.pop_front();
        chk("wr_kind", {bus.sigma_we, bus.mu_we}, e.kind);
        chk("wr_addr", bus.sigma_we ? bus.sigma_addr : 10'(bus.mu_addr), e.addr);
        chk("wr_data", bus.write_data, e.data);
      end
    end
    if (bus.result_valid) begin
      if (rq.size() == 0) chk("res_spurious", bus.result_valid, 0);
      else begin
        chk("result", bus.result, rq[0]);
        if (bus.result_ready) void'(rq.pop_front());
      end
    end
    if (bus.start) begin
      nstart++;
      sw_exp = ~sw_exp;
      chk("start_switch", bus.pp_switch, sw_exp);
      chk("start_after_write", pmu, 0);
      chk("start_width", pst, 0);
    end else if (!rst && !prst && bus.pp_switch != psw) chk("switch_hold", bus.pp_switch, psw);
    psw = bus.pp_switch;
    prst = rst;
    pst = bus.start;
    pmu = bus.mu_we;
  end
  initial begin
    #500000;
    failures++;
    $display("FAIL global_timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial begin
    int k;
    int n;
    logic seen;
    bus.load_data = '0;
    bus.load_valid = 1'b0;
    bus.core_done = '0;
    bus.core_acc = '0;
    bus.result_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("ready_in_rst", bus.load_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_bus", {bus.sigma_addr, bus.mu_addr, bus.write_data, bus.sigma_we, bus.mu_we}, 0);
    chk("rst_ctl", {bus.pp_switch, bus.start, bus.result, bus.result_valid, bus.busy, bus.timeout}, 0);
    chk("rst_ready", bus.load_ready, 1);
    // first table set, value = index
    @(posedge clk);
    #1;
    load_words(0, SN + MN);
    @(negedge clk);
    chk("ready_full", bus.load_ready, 0);
    chk("switch_pre", bus.pp_switch, 0);
    wait_start;
    @(posedge clk);
    #1;
    chk("busy_run", bus.busy, 1);
    // second set loaded while the bank runs
    load_words(5000, SN + MN);
    chk("busy_loaded", bus.busy, 1);
    chk("ready_full2", bus.load_ready, 0);
    bus.core_acc = {27'd400, 27'd300, 27'd200, 27'd100};
    rq.push_back(64'd1000);
    pulse_done(4'b0001);
    repeat (2) @(posedge clk);
    #1;
    pulse_done(4'b0100);
    pulse_done(4'b0010);
    repeat (3) @(posedge clk);
    #1;
    bus.core_done = 4'b1000;
    k = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1 bus.core_done = '0;
      k++;
      @(negedge clk);
      seen = bus.result_valid;
    end
    chk("valid_latency", k, NCORES + 1);
    repeat (5) @(posedge clk);
    #1 bus.result_ready = 1'b1;
    @(posedge clk);
    #1 bus.result_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop", bus.result_valid, 0);
    chk("no_early_start", bus.start, 0);
    @(negedge clk);
    chk("restart", bus.start, 1);
    // saturated accumulators
    @(posedge clk);
    #1;
    bus.core_acc = {4{27'h7FFFFFF}};
    rq.push_back(64'd536870908);
    bus.result_ready = 1'b1;
    pulse_done(4'b1111);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.result_valid;
    end
    chk("valid_max", seen, 1);
    @(posedge clk);
    #1 bus.result_ready = 1'b0;
    @(negedge clk);
    chk("valid_drop2", bus.result_valid, 0);
    chk("rq_empty", rq.size(), 0);
    // watchdog: only three cores finish
    @(posedge clk);
    #1;
    load_words(9000, SN + MN);
    wait_start;
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT + 50 && !seen; i++) begin
      @(posedge clk);
      n++;
      #1 bus.core_done = (n == 1) ? 4'b0111 : 4'b0000;
      @(negedge clk);
      seen = bus.timeout;
    end
    chk("timeout_cycles", n, TIMEOUT);
    chk("timeout_idle", bus.busy, 0);
    chk("timeout_no_valid", bus.result_valid, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("timeout_sticky", bus.timeout, 1);
    // reset during RUN and mid-load
    @(posedge clk);
    #1;
    load_words(11000, SN + MN);
    wait_start;
    @(posedge clk);
    #1;
    load_words(13000, 300);
    rst = 1'b1;
    @(negedge clk);
    chk("ready_in_rst2", bus.load_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    chk("wq_drain", wq.size(), 0);
    wq.delete();
    wpos = 0;
    sw_exp = 1'b0;
    @(negedge clk);
    chk("rst2_bus", {bus.sigma_addr, bus.mu_addr, bus.write_data, bus.sigma_we, bus.mu_we}, 0);
    chk("rst2_ctl", {bus.pp_switch, bus.start, bus.result, bus.result_valid, bus.busy, bus.timeout}, 0);
    chk("rst2_ready", bus.load_ready, 1);
    @(posedge clk);
    #1;
    load_words(20000, 5);
    repeat (2) @(negedge clk);
    chk("reload_done", wq.size(), 0);
    chk("start_count", nstart, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mc_scheduler.md
Name: mc_scheduler

Overview:
- Sequences a bank of NCORES Monte-Carlo cores that share one broadcast table-write bus and one start/switch pair.
- Streams host table words (exp-sigma table, then mu table) into the inactive half of every core's ping-pong RAMs.
- Flips the switch and pulses start once a full table set is loaded and the bank is idle, then waits for every core's done.
- Sums the per-core accumulators into one result, returned to the host with a valid/ready handshake.

Parameters:
- NCORES, 4, number of cores driven.
- LOG_NCORES, 2, log2(NCORES).
- logT, 9, log2 of timesteps; mu table depth 2^logT.
- pathWidth, 10, sigma table address width; depth 2^pathWidth.
- ACC_W, 27, per-core accumulator width (18+logT).
- TIMEOUT, 4096, max cycles from start to all-done.

Ports:
- CLK  in  1  clock.
- iReset  in  1  synchronous active-high reset.
- iLoadData  in  18  host table word.
- iLoadValid  in  1  host word valid.
- oLoadReady  out  1  scheduler accepts word this cycle.
- oSigmaWriteAddress  out  pathWidth  broadcast sigma RAM write address.
- oMuWriteAddress  out  logT  broadcast mu RAM write address.
- oWriteData  out  18  broadcast write data (registered iLoadData).
- oSigmaWE  out  1  sigma write enable.
- oMuWE  out  1  mu write enable.
- oSwitch  out  1  ping-pong select to all cores.
- oStart  out  1  one-cycle start pulse to all cores.
- iCoreDone  in  NCORES  per-core done pulses.
- iCoreAcc  in  NCORES*ACC_W  concatenated accumulators; core k at bits [k*ACC_W +: ACC_W].
- oResult  out  ACC_W+LOG_NCORES  summed result.
- oResultValid  out  1  result valid.
- iResultReady  in  1  host accepts result.
- oBusy  out  1  run FSM not IDLE.
- oTimeout  out  1  sticky; set on watchdog expiry; cleared only by reset.

Behaviour:
- Reset: all outputs 0. Load address 0. bufFull=0. Run FSM IDLE. Done mask 0.
- Load engine (independent of run FSM):
  - oLoadReady = ~bufFull & ~iReset.
  - Transfer when iLoadValid & oLoadReady.
  - Words 0..2^pathWidth-1 go to sigma; the next 2^logT words go to mu.
  - Write is registered: WE, address and data appear one cycle after the transfer; WE is high for exactly one cycle per word.
  - After the final mu word: bufFull=1 and the load counter wraps to 0.
  - Loads may proceed during RUN; they target the half not selected for reading.
- Run FSM:
  - IDLE: if bufFull → toggle oSwitch, clear bufFull, pulse oStart for 1 cycle, clear done mask and watchdog, go RUN.
    - If bufFull is set on the same cycle as a final-word write, the start waits until the write cycle has completed, so the last write never coincides with the switch flip.
  - RUN: done mask |= iCoreDone each cycle.
    - When mask is all ones → SUM.
    - Watchdog counts cycles; on reaching TIMEOUT → set oTimeout, go IDLE. No result is produced.
  - SUM: sequential adder over NCORES cycles, core 0 first. Sum is zero-extended, width ACC_W+LOG_NCORES, with no overflow possible. Then → OUT.
  - OUT: oResult stable, oResultValid=1 until iResultReady, then → IDLE.
    - oResultValid drops the cycle after the handshake.
    - A new start may occur the cycle after returning to IDLE.
- iCoreDone pulses outside RUN are ignored.
- oSwitch changes only in the IDLE→RUN transition.
- oBusy = state≠IDLE.
- Reset mid-operation: everything returns to reset state; a partial load is discarded.

Test Plan:
- Load 1024 sigma words (value = index) + 512 mu words:
  - oSigmaWE high for 1024 cycles, addresses 0..1023, then oMuWE for 512 cycles with addresses 0..511.
  - Then oLoadReady=0, oSwitch 0→1, oStart one pulse.
- After start, done pulses from cores 0..3 on different cycles with accs 100, 200, 300, 400:
  - oResult=1000, oResultValid asserted NCORES+1 cycles after the last done.
  - Hold iResultReady low 5 cycles → result stable throughout.
- Second table set loaded during RUN:
  - oLoadReady stays high during RUN.
  - Next start occurs immediately after OUT handshake; oSwitch 1→0.
- Max accs (all 2^27-1, 4 cores) → oResult = 4*(2^27-1) exactly, no wrap.
- Only 3 cores signal done → at TIMEOUT cycles, oTimeout=1, FSM IDLE, no oResultValid.
- Assert iReset during RUN and mid-load:
  - Next cycle all outputs 0 and oLoadReady=1.
  - The new load restarts at sigma address 0.
